sr_ff_seq_ctrl: RTL and testbench
=================================

SR_FF_SEQ_CTRL -- requirements
Module: sr_ff_seq_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning wait cycles after driving S/R before sampling q (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to run one test sequence.
REQ-005 SHALL have port q_in, input, 1 bit: q output of the SR flip-flop under control.
REQ-006 SHALL have port s, output, 2 bits: set drive to the flip-flop; bit 1 is always 0.
REQ-007 SHALL have port r, output, 2 bits: reset drive to the flip-flop; bit 1 is always 0.
REQ-008 SHALL have port busy, output, 1 bit: high while a sequence runs.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse at sequence end.
REQ-010 SHALL have port pass, output, 1 bit: last sequence had zero mismatches.
REQ-011 SHALL have port step, output, 3 bits: index of the step in progress.
REQ-012 SHALL have port err_cnt, output, 3 bits: mismatch count of the current or last sequence.

Function
REQ-013 SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-014 SHALL step through this table: 0: s=0,r=1,exp 0; 1: s=1,r=0,exp 1; 2: s=0,r=0,exp 1 (hold); 3: s=0,r=1,exp 0.
REQ-015 SHALL, in IDLE with start=1, clear err_cnt and step and enter DRIVE; busy rises on the next cycle.
REQ-016 SHALL ignore start while busy=1 or in DONE.
REQ-017 SHALL, in DRIVE, register the step's s/r values (held until the next DRIVE or IDLE) and go to WAIT.
REQ-018 SHALL stay in WAIT for exactly SETTLE cycles using a 4-bit counter, then go to CHECK.
REQ-019 SHALL, in CHECK, compare q_in with the expected value and increment err_cnt on mismatch.
REQ-020 SHALL saturate err_cnt at 7.
REQ-021 SHALL, after CHECK, advance step and enter DRIVE, or enter DONE after the last step.
REQ-022 SHALL, in DONE, assert done for one cycle, load pass = (err_cnt==0), drop busy and return to IDLE.
REQ-023 SHALL make each step take SETTLE+2 cycles, so done asserts steps*(SETTLE+2) cycles after the DRIVE of step 0.
REQ-024 SHALL hold step, err_cnt and pass stable in IDLE until the next accepted start.
REQ-025 SHALL drive s=0 and r=0 (hold) in IDLE.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, enter IDLE and clear s, r, busy, done, pass, step, err_cnt and the wait counter, regardless of state.
REQ-027 SHALL give rst priority over start when both are high in the same cycle; a sequence aborted by rst produces no done pulse.

Configuration
REQ-028 SHALL use macro SR_SEQ_INVALID_STEP_EN to enable or disable the invalid-input step.
REQ-029 SHALL, with SR_SEQ_INVALID_STEP_EN defined, append step 4: s=1, r=1, exp 0 (reset-dominant), giving 5 steps.
REQ-030 SHALL, without SR_SEQ_INVALID_STEP_EN, run 4 steps and never drive s=1 and r=1 together.

Verification
REQ-031 SHALL verify: ideal SR-flip-flop model, SETTLE=1, start pulse -> done 12 cycles after DRIVE of step 0, err_cnt=0, pass=1.
REQ-032 SHALL verify: q_in stuck at 0 -> mismatches on steps 1 and 2, err_cnt=2, pass=0.
REQ-033 SHALL verify: q_in stuck at 1 -> err_cnt=2, pass=0; with macro defined -> err_cnt=3 and done at 15 cycles.
REQ-034 SHALL verify: start re-pulsed during step 2 -> no restart, step keeps advancing, exactly one done pulse.
REQ-035 SHALL verify: rst asserted during WAIT of step 1 -> next cycle IDLE, s=r=0, busy=0, err_cnt=0, no done pulse.
REQ-036 SHALL verify: SETTLE=15 -> 17 cycles per step, q_in sampled only in CHECK, not earlier.

Source files
------------

// File: rtl/sr_ff_seq_ctrl_if.sv
// Control/observation bundle between the SR flip-flop sequencer and its environment.
// The slave side is the sequencer; the master side drives start and returns the flip-flop q.
interface sr_ff_seq_ctrl_if;
  logic       start;
  logic       q_in;
  logic [1:0] s;
  logic [1:0] r;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] step;
  logic [2:0] err_cnt;

  modport master (
    output start, q_in,
    input  s, r, busy, done, pass, step, err_cnt
  );

  modport slave (
    input  start, q_in,
    output s, r, busy, done, pass, step, err_cnt
  );
endinterface

// File: rtl/sr_ff_seq_ctrl.sv
// Sequencer that exercises an external SR flip-flop through a fixed step table and counts q mismatches.
// Define SR_SEQ_INVALID_STEP_EN to append a fifth step with s=1,r=1 expecting reset-dominant q=0.
module sr_ff_seq_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input logic              clk,
  input logic              rst,
  sr_ff_seq_ctrl_if.slave  bus
);

`ifdef SR_SEQ_INVALID_STEP_EN
  localparam int unsigned NUM_STEPS = 5;
`else
  localparam int unsigned NUM_STEPS = 4;
`endif
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);
  localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] ERR_MAX   = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic       s_q, s_nxt;
  logic       r_q, r_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;
  logic       pass_q, pass_nxt;
  logic [2:0] step_q, step_nxt;
  logic [2:0] err_q, err_nxt;
  logic [3:0] cnt_q, cnt_nxt;

  logic tbl_s, tbl_r, tbl_exp;

  // Step table: drive values and the q expected once they have settled.
  always_comb begin
    case (step_q)
      3'd0:    {tbl_s, tbl_r, tbl_exp} = 3'b010;
      3'd1:    {tbl_s, tbl_r, tbl_exp} = 3'b101;
      3'd2:    {tbl_s, tbl_r, tbl_exp} = 3'b001;
      3'd3:    {tbl_s, tbl_r, tbl_exp} = 3'b010;
`ifdef SR_SEQ_INVALID_STEP_EN
      3'd4:    {tbl_s, tbl_r, tbl_exp} = 3'b110;
`endif
      default: {tbl_s, tbl_r, tbl_exp} = 3'b000;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_nxt = state;
    s_nxt     = s_q;
    r_nxt     = r_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    pass_nxt  = pass_q;
    step_nxt  = step_q;
    err_nxt   = err_q;
    cnt_nxt   = cnt_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = DRIVE;
          step_nxt  = 3'd0;
          err_nxt   = 3'd0;
          busy_nxt  = 1'b1;
        end
      end
      DRIVE: begin
        s_nxt     = tbl_s;
        r_nxt     = tbl_r;
        cnt_nxt   = 4'd0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) state_nxt = CHECK;
        else                    cnt_nxt   = cnt_q + 4'd1;
      end
      CHECK: begin
        if ((bus.q_in != tbl_exp) && (err_q != ERR_MAX)) err_nxt = err_q + 3'd1;
        if (step_q == LAST_STEP) begin
          // pass is loaded alongside done so both are valid in the same cycle.
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == 3'd0);
        end else begin
          step_nxt  = step_q + 3'd1;
          state_nxt = DRIVE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments and a synchronous reset that wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      step_q <= 3'd0;
      err_q  <= 3'd0;
      cnt_q  <= 4'd0;
    end else begin
      state  <= state_nxt;
      s_q    <= s_nxt;
      r_q    <= r_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      pass_q <= pass_nxt;
      step_q <= step_nxt;
      err_q  <= err_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

  assign bus.s       = {1'b0, s_q};
  assign bus.r       = {1'b0, r_q};
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.step    = step_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_sr_ff_seq_ctrl.sv
// Bench for sr_ff_seq_ctrl: SETTLE=1 and SETTLE=15 instances run side by side against a
// cycle-indexed model of the step table; q_in comes from an ideal SR model, stuck values or noise.
module tb_sr_ff_seq_ctrl;

`ifdef SR_SEQ_INVALID_STEP_EN
  localparam int N_STEPS = 5;
`else
  localparam int N_STEPS = 4;
`endif

  typedef enum int {Q_IDEAL, Q_ZERO, Q_ONE, Q_RAND} q_mode_t;

  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  sr_ff_seq_ctrl_if bus_a();
  sr_ff_seq_ctrl_if bus_b();

  sr_ff_seq_ctrl #(.SETTLE(1))  dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  sr_ff_seq_ctrl #(.SETTLE(15)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  logic       q_v    [2];
  logic [1:0] s_v    [2];
  logic [1:0] r_v    [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic       pass_v [2];
  logic [2:0] step_v [2];
  logic [2:0] err_v  [2];

  assign bus_a.start = start;
  assign bus_b.start = start;
  assign bus_a.q_in  = q_v[0];
  assign bus_b.q_in  = q_v[1];

  assign s_v[0] = bus_a.s;       assign s_v[1] = bus_b.s;
  assign r_v[0] = bus_a.r;       assign r_v[1] = bus_b.r;
  assign busy_v[0] = bus_a.busy; assign busy_v[1] = bus_b.busy;
  assign done_v[0] = bus_a.done; assign done_v[1] = bus_b.done;
  assign pass_v[0] = bus_a.pass; assign pass_v[1] = bus_b.pass;
  assign step_v[0] = bus_a.step; assign step_v[1] = bus_b.step;
  assign err_v[0]  = bus_a.err_cnt; assign err_v[1] = bus_b.err_cnt;

  // Step table as the sequence is meant to exercise the flip-flop.
  int tbl_s   [5] = '{0, 1, 0, 0, 1};
  int tbl_r   [5] = '{1, 0, 0, 1, 1};
  int tbl_exp [5] = '{0, 1, 1, 0, 0};

  int          n_checks = 0;
  int          n_fail   = 0;
  q_mode_t     q_mode;
  logic        q_ff [2];
  int unsigned mism [2];

  task automatic check(input string tag, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 15;
  endfunction

  function automatic int unsigned sat7(input int unsigned v);
    return (v > 7) ? 7 : v;
  endfunction

  // Environment flip-flop: reacts to the drive currently presented by each sequencer.
  task automatic update_q();
    for (int i = 0; i < 2; i++) begin
      case (q_mode)
        Q_IDEAL: begin
          if (r_v[i][0])      q_ff[i] = 1'b0;
          else if (s_v[i][0]) q_ff[i] = 1'b1;
          q_v[i] = q_ff[i];
        end
        Q_ZERO:  q_v[i] = 1'b0;
        Q_ONE:   q_v[i] = 1'b1;
        default: q_v[i] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic check_idle_zero(input int i, input string why);
    check($sformatf("%s busy[%0d]", why, i), busy_v[i], 0);
    check($sformatf("%s done[%0d]", why, i), done_v[i], 0);
    check($sformatf("%s pass[%0d]", why, i), pass_v[i], 0);
    check($sformatf("%s step[%0d]", why, i), step_v[i], 0);
    check($sformatf("%s err[%0d]",  why, i), err_v[i],  0);
    check($sformatf("%s s[%0d]",    why, i), s_v[i],    0);
    check($sformatf("%s r[%0d]",    why, i), r_v[i],    0);
  endtask

  // Expected outputs of instance i at cycle c, where c=0 is the DRIVE cycle of step 0.
  task automatic observe(input int i, input int c);
    int p     = settle_of(i) + 2;
    int end_c = N_STEPS * p;
    int stp;
    int off;
    check($sformatf("busy[%0d] c%0d", i, c), busy_v[i], (c < end_c) ? 1 : 0);
    check($sformatf("done[%0d] c%0d", i, c), done_v[i], (c == end_c) ? 1 : 0);
    check($sformatf("err[%0d] c%0d",  i, c), err_v[i],  sat7(mism[i]));
    check($sformatf("s1[%0d] c%0d",   i, c), s_v[i][1], 0);
    check($sformatf("r1[%0d] c%0d",   i, c), r_v[i][1], 0);
`ifndef SR_SEQ_INVALID_STEP_EN
    check($sformatf("sr_both[%0d] c%0d", i, c), s_v[i][0] & r_v[i][0], 0);
`endif
    if (c < end_c) begin
      stp = c / p;
      off = c % p;
      check($sformatf("step[%0d] c%0d", i, c), step_v[i], stp);
      if (off >= 1) begin
        check($sformatf("s[%0d] c%0d", i, c), s_v[i][0], tbl_s[stp]);
        check($sformatf("r[%0d] c%0d", i, c), r_v[i][0], tbl_r[stp]);
      end
      if (off == p - 1 && int'(q_v[i]) != tbl_exp[stp]) mism[i]++;
    end else begin
      check($sformatf("step_end[%0d] c%0d", i, c), step_v[i], N_STEPS - 1);
      check($sformatf("pass[%0d] c%0d", i, c), pass_v[i], (mism[i] == 0) ? 1 : 0);
      if (c > end_c) begin
        check($sformatf("s_idle[%0d] c%0d", i, c), s_v[i], 0);
        check($sformatf("r_idle[%0d] c%0d", i, c), r_v[i], 0);
      end
    end
  endtask

  // One full sequence on both instances; repulse re-asserts start while A is mid-run and in DONE.
  task automatic run_seq(input q_mode_t mode, input bit repulse);
    int last = N_STEPS * 17 + 3;
    q_mode  = mode;
    mism[0] = 0;
    mism[1] = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c <= last; c++) begin
      if (c != 0) begin
        @(posedge clk);
        #1;
      end
      start = repulse && (c == 7 || c == N_STEPS * 3);
      update_q();
      @(negedge clk);
      observe(0, c);
      observe(1, c);
    end
    start = 1'b0;
  endtask

  // Reset during WAIT of step 1 on instance A, then reset colliding with start.
  task automatic run_abort();
    q_mode  = Q_RAND;
    mism[0] = 0;
    mism[1] = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      if (c != 0) begin
        @(posedge clk);
        #1;
      end
      update_q();
      @(negedge clk);
      observe(0, c);
      observe(1, c);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero(0, "abort");
    check_idle_zero(1, "abort");
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      check($sformatf("abort_done[0] c%0d", c), done_v[0], 0);
      check($sformatf("abort_done[1] c%0d", c), done_v[1], 0);
      check($sformatf("abort_busy[0] c%0d", c), busy_v[0], 0);
    end
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle_zero(0, "rst_vs_start");
    check_idle_zero(1, "rst_vs_start");
    @(negedge clk);
    check("rst_vs_start busy[0] later", busy_v[0], 0);
    check("rst_vs_start busy[1] later", busy_v[1], 0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    q_v[0]  = 1'b0;
    q_v[1]  = 1'b0;
    q_ff[0] = 1'b0;
    q_ff[1] = 1'b0;
    q_mode  = Q_IDEAL;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_zero(0, "reset");
    check_idle_zero(1, "reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero(0, "post_reset");

    run_seq(Q_IDEAL, 1'b0);
    run_seq(Q_ZERO,  1'b0);
    run_seq(Q_ONE,   1'b1);
    run_seq(Q_IDEAL, 1'b1);
    for (int k = 0; k < 4; k++) run_seq(Q_RAND, k[0]);
    run_abort();
    run_seq(Q_IDEAL, 1'b0);
    run_seq(Q_RAND,  1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
